fetch_sequencer: RTL and testbench

//  Sequences the byte-addressed instruction memory: owns the PC register, drives

---
 rtl/fetch_sequencer.sv | 77 +++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC register and fetch queue feeding decode; FETCH_ALIGN_CHECK_EN adds misaligned-redirect halt
module fetch_sequencer #(
  parameter int PC_W = 12,
  parameter int INST_W = 32,
  parameter int RESET_PC = 0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              halted
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic deq, enq, bad;
`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  assign bad = redirect_valid & |redirect_pc[1:0];
  assign misalign = misalign_q;
  always_ff @(posedge clk)
    if (rst) misalign_q <= 1'b0;
    else if (bad) misalign_q <= 1'b1;
`else
  assign bad = 1'b0;
`endif
  assign imem_addr = pc_q;
  assign halted = state_q == HALT;
  assign if_valid = count_q != '0;
  assign if_pc = if_valid ? pc_mem[rd_q] : '0;
  assign if_inst = if_valid ? inst_mem[rd_q] : '0;
  assign deq = if_valid & if_ready;
  assign enq = state_q == RUN & ~redirect_valid & ~halt_req & (count_q < (AW+1)'(DEPTH) | deq);
  always_comb begin
    state_d = (halt_req | bad) ? HALT : state_q;
    pc_d = redirect_valid ? (bad ? pc_q : redirect_pc & ~PC_W'(3)) : enq ? pc_q + PC_W'(4) : pc_q;
    count_d = redirect_valid ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
    rd_d = redirect_valid ? '0 : rd_q + AW'(deq);
    wr_d = redirect_valid ? '0 : wr_q + AW'(enq);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RUN;
      pc_q <= PC_W'(RESET_PC);
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  always_ff @(posedge clk)
    if (enq) begin
      pc_mem[wr_q] <= pc_q;
      inst_mem[wr_q] <= imem_data;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queue-level reference model checked every cycle
module tb_fetch_sequencer;
  logic clk = 1'b0, rst, redirect_valid, halt_req, if_ready, if_valid, halted;
  logic [11:0] imem_addr, redirect_pc, if_pc;
  logic [31:0] imem_data, if_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  bit mmis;
`endif
  logic [7:0] mem [4096];
  logic [43:0] mq [$];
  logic [11:0] mpc, saved;
  logic [15:0] pat;
  bit mhalt, started, d, e;
  int tests, fails;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .halted(halted)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  function automatic logic [31:0] word(logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  assign imem_data = word(imem_addr);

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference: fetch queue as a list of {pc,inst}, one update per rising edge
  initial begin
    mpc = 0;
    mhalt = 0;
    forever begin
      @(posedge clk);
      started = 1;
      if (rst) begin
        mq.delete();
        mpc = 0;
        mhalt = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        mmis = 0;
`endif
      end else begin
        d = mq.size() > 0 && if_ready;
        e = !mhalt && !redirect_valid && !halt_req && (mq.size() < 2 || d);
        if (redirect_valid) begin
          mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            mmis = 1;
            mhalt = 1;
          end else mpc = redirect_pc;
`else
          mpc = redirect_pc & 12'hFFC;
`endif
        end else begin
          if (d) void'(mq.pop_front());
          if (e) begin
            mq.push_back({mpc, word(mpc)});
            mpc = mpc + 12'd4;
          end
        end
        if (halt_req) mhalt = 1;
      end
    end
  end

  always @(negedge clk)
    if (started) begin
      chk("if_valid", {31'd0, if_valid}, {31'd0, mq.size() > 0});
      chk("if_pc", {20'd0, if_pc}, mq.size() > 0 ? {20'd0, mq[0][43:32]} : 32'd0);
      chk("if_inst", if_inst, mq.size() > 0 ? mq[0][31:0] : 32'd0);
      chk("imem_addr", {20'd0, imem_addr}, {20'd0, mpc});
      chk("halted", {31'd0, halted}, {31'd0, mhalt});
`ifdef FETCH_ALIGN_CHECK_EN
      chk("misalign", {31'd0, misalign}, {31'd0, mmis});
`endif
    end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) & 255);
    mem[0] = 8'd19; mem[1] = 8'd6; mem[2] = 8'd80; mem[3] = 8'd0;
    mem[4] = 8'd147; mem[5] = 8'd102; mem[6] = 8'd176; mem[7] = 8'd0;
    rst = 1; if_ready = 1; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    // 1: latency and first two instructions
    @(posedge clk); #1 rst = 0;
    @(posedge clk); @(negedge clk);
    chk("t1 pc0", {20'd0, if_pc}, 32'h0);
    chk("t1 inst0", if_inst, 32'h00500613);
    @(negedge clk);
    chk("t1 pc4", {20'd0, if_pc}, 32'h4);
    chk("t1 inst4", if_inst, 32'h00B06693);
    // 2: backpressure from a fresh reset, then ordered release
    rst = 1; if_ready = 0;
    @(negedge clk); rst = 0;
    repeat (5) @(negedge clk);
    chk("t2 stall addr", {20'd0, imem_addr}, 32'h008);
    if_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t2 order", {20'd0, if_pc}, 32'(4 * k));
      @(negedge clk);
    end
    // 3: redirect with two queued and decode accepting
    chk("t3 full", {31'd0, if_valid}, 32'd1);
    redirect_valid = 1; redirect_pc = 12'h020;
    @(negedge clk); redirect_valid = 0;
    chk("t3 flushed", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("t3 target", {20'd0, if_pc}, 32'h020);
    // 4: wrap
    redirect_valid = 1; redirect_pc = 12'hFFC;
    @(negedge clk); redirect_valid = 0;
    @(negedge clk);
    chk("t4 ffc", {20'd0, if_pc}, 32'hFFC);
    @(negedge clk);
    chk("t4 wrap", {20'd0, if_pc}, 32'h000);
    // 5: halt with two queued, drain, freeze
    if_ready = 0;
    repeat (3) @(negedge clk);
    halt_req = 1;
    @(negedge clk); halt_req = 0; if_ready = 1; saved = imem_addr;
    chk("t5 halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    chk("t5 drain1", {31'd0, if_valid}, 32'd1);
    @(negedge clk);
    chk("t5 empty", {31'd0, if_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5 frozen", {20'd0, imem_addr}, {20'd0, saved});
    // 7: mixed readiness, redirect, then halt+redirect together
    rst = 1;
    @(negedge clk); rst = 0;
    chk("t7 reset halted", {31'd0, halted}, 32'd0);
    pat = 16'b1011_0010_1110_0111;
    for (int i = 0; i < 16; i++) begin
      if_ready = pat[i];
      redirect_valid = i == 6 || i == 12;
      redirect_pc = i == 6 ? 12'h7F8 : 12'h100;
      halt_req = i == 12;
      @(negedge clk);
    end
    redirect_valid = 0; halt_req = 0;
    chk("t7 halted", {31'd0, halted}, 32'd1);
    chk("t7 addr", {20'd0, imem_addr}, 32'h100);
    chk("t7 empty", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    // 6: misaligned redirect
    rst = 1;
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    redirect_valid = 1; redirect_pc = 12'h012;
    @(negedge clk); redirect_valid = 0;
    chk("t6 misalign", {31'd0, misalign}, 32'd1);
    chk("t6 halted", {31'd0, halted}, 32'd1);
    chk("t6 empty", {31'd0, if_valid}, 32'd0);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("t6 cleared", {31'd0, misalign}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
